mux_scan_ctrl: RTL

Sequencer that sits directly upstream of the 16:1 multiplexer `n_1mux`. It drives the mux `sel` lines and sweeps the enabled channels in ascending order. It holds each channel long enough for the mux output to settle, then samples `y` into a per-channel result word. A start/busy/done handshake lets a host trigger one full scan and read all sixteen sampled bits atomically.

---
 rtl/mux_scan_pkg.sv | 14 +
 rtl/mux_next_ch.sv | 26 ++
 rtl/mux_scan_ctrl.sv | 124 ++++++++++++
 3 files changed

// File: rtl/mux_scan_pkg.sv
// Shared defaults and FSM state type for the mux scan sequencer.
package mux_scan_pkg;

    localparam int unsigned N_SEL_DEF = 4;
    localparam int unsigned N_CH_DEF  = 2 ** N_SEL_DEF;
    localparam int unsigned CNT_W     = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/mux_next_ch.sv
// Priority finder: lowest set mask bit strictly above cur, or the lowest
// set bit overall when from_lowest is high (the "below 0" seed).
module mux_next_ch #(
    parameter  int unsigned N_SEL = 4,
    localparam int unsigned N_CH  = 2 ** N_SEL
) (
    input  logic [N_CH-1:0]  mask_q,
    input  logic [N_SEL-1:0] cur,
    input  logic             from_lowest,
    output logic [N_SEL-1:0] next_sel,
    output logic             found
);

    // Ascending search; the first qualifying bit wins.
    always_comb begin
        next_sel = '0;
        found    = 1'b0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            if (!found && mask_q[i] && (from_lowest || (i > int'(cur)))) begin
                found    = 1'b1;
                next_sel = N_SEL'(i);
            end
        end
    end

endmodule

// File: rtl/mux_scan_ctrl.sv
// Scan sequencer for a 2**N_SEL:1 mux: steps sel over enabled channels,
// holds each for SETTLE cycles, samples mux_y into a per-channel result.
module mux_scan_ctrl
    import mux_scan_pkg::*;
#(
    parameter  int unsigned N_SEL  = N_SEL_DEF,
    parameter  int unsigned SETTLE = 2,
    localparam int unsigned N_CH   = 2 ** N_SEL
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [N_CH-1:0]  mask,
    input  logic             mux_y,
    output logic [N_SEL-1:0] sel,
    output logic             busy,
    output logic             done,
    output logic [N_CH-1:0]  result
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(SETTLE - 1);

    state_t           state, state_nxt;
    logic [N_SEL-1:0] sel_nxt;
    logic [CNT_W-1:0] settle_cnt, cnt_nxt;
    logic [N_CH-1:0]  mask_q, mask_nxt;
    logic [N_CH-1:0]  work, work_nxt;
    logic [N_CH-1:0]  res_nxt;
    logic             done_nxt;

    logic [N_CH-1:0]  find_mask;
    logic             find_lowest;
    logic [N_SEL-1:0] next_sel;
    logic             found;

    // In IDLE the raw mask is searched from the bottom, since mask_q is
    // only written on the same edge that loads the first channel.
    assign find_mask   = (state == ST_IDLE) ? mask : mask_q;
    assign find_lowest = (state == ST_IDLE);

    mux_next_ch #(
        .N_SEL (N_SEL)
    ) u_next (
        .mask_q      (find_mask),
        .cur         (sel),
        .from_lowest (find_lowest),
        .next_sel    (next_sel),
        .found       (found)
    );

    assign busy = (state == ST_SCAN);

    // Next-state and datapath update. result and done are loaded on the
    // edge entering DONE so both are visible during the DONE cycle itself.
    always_comb begin
        state_nxt = state;
        sel_nxt   = sel;
        cnt_nxt   = settle_cnt;
        mask_nxt  = mask_q;
        work_nxt  = work;
        res_nxt   = result;
        done_nxt  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    mask_nxt = mask;
                    work_nxt = '0;
                    cnt_nxt  = '0;
                    if (found) begin
                        sel_nxt   = next_sel;
                        state_nxt = ST_SCAN;
                    end else begin
                        res_nxt   = '0;
                        done_nxt  = 1'b1;
                        state_nxt = ST_DONE;
                    end
                end
            end
            ST_SCAN: begin
                if (settle_cnt == LAST) begin
                    work_nxt[sel] = mux_y;
                    if (found) begin
                        sel_nxt = next_sel;
                        cnt_nxt = '0;
                    end else begin
                        res_nxt   = work_nxt;
                        done_nxt  = 1'b1;
                        state_nxt = ST_DONE;
                    end
                end else begin
                    cnt_nxt = settle_cnt + CNT_W'(1);
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            sel        <= '0;
            settle_cnt <= '0;
            mask_q     <= '0;
            work       <= '0;
            result     <= '0;
            done       <= 1'b0;
        end else begin
            state      <= state_nxt;
            sel        <= sel_nxt;
            settle_cnt <= cnt_nxt;
            mask_q     <= mask_nxt;
            work       <= work_nxt;
            result     <= res_nxt;
            done       <= done_nxt;
        end
    end

endmodule
